reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 157 +++++++++++++++
 tb/tb_reg_file_sb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with per-entry pending (scoreboard) bits, a hardwired zero register,
// optional write-to-read forwarding and a multi-cycle bulk clear sequenced by a small FSM.
module reg_file_sb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              clr_busy_q;
    logic              clr_busy_d;

    logic clearing;
    logic wr_live;
    logic hit_a;
    logic hit_b;

    assign clearing = (state_q == CLEAR);
    assign wr_live  = !clearing && wr_en && (wr_addr != ZERO_A);
    assign hit_a    = (BYPASS != 0) && wr_live && (wr_addr == rd_addr_a);
    assign hit_b    = (BYPASS != 0) && wr_live && (wr_addr == rd_addr_b);

    // Next-state for storage, pending bits and the clear sequencer.
    always_comb begin
        mem_d      = mem_q;
        pend_d     = pend_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_busy_d = clr_busy_q;
        case (state_q)
            IDLE: begin
                if (wr_live) begin
                    mem_d[wr_addr] = wr_data;
                end
                if (wr_en) begin
                    pend_d[wr_addr] = 1'b0;
                end
                // Applied after the write-side clear so a same-address reserve wins.
                if (rsv_en && (rsv_addr != ZERO_A)) begin
                    pend_d[rsv_addr] = 1'b1;
                end
                if (clr_req) begin
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    clr_busy_d = 1'b1;
                end
            end
            CLEAR: begin
                mem_d[cnt_q]  = '0;
                pend_d[cnt_q] = 1'b0;
                if (cnt_q == LAST_A) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    clr_busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                clr_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    // Zero register dominates; during a clear no forwarding and busy is forced high.
    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        busy_a    = pend_q[rd_addr_a];
        if (rd_addr_a == ZERO_A) begin
            rd_data_a = '0;
            busy_a    = 1'b0;
        end else if (clearing) begin
            busy_a = 1'b1;
        end else if (hit_a) begin
            rd_data_a = wr_data;
            busy_a    = 1'b0;
        end
    end

    always_comb begin
        rd_data_b = mem_q[rd_addr_b];
        busy_b    = pend_q[rd_addr_b];
        if (rd_addr_b == ZERO_A) begin
            rd_data_b = '0;
            busy_b    = 1'b0;
        end else if (clearing) begin
            busy_b = 1'b1;
        end else if (hit_b) begin
            rd_data_b = wr_data;
            busy_b    = 1'b0;
        end
    end

    assign clr_busy  = clr_busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a forwarding instance and a non-forwarding instance share all inputs
// and are checked against directed vectors, clear/reset sequences and a randomized array model.
module tb_reg_file_sb;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int ZR    = 31;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en, rsv_en, clr_req;
    logic [DW-1:0] rd_data_a, rd_data_b, rd_data_a_nb, rd_data_b_nb;
    logic          busy_a, busy_b, busy_a_nb, busy_b_nb;
    logic          clr_busy, clr_busy_nb, dbg_state, dbg_state_nb;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .dbg_state(dbg_state)
    );

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a_nb), .rd_data_b(rd_data_b_nb),
        .busy_a(busy_a_nb), .busy_b(busy_b_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy_nb), .dbg_state(dbg_state_nb)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: plain arrays plus the number of clear cycles still to run.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pend [DEPTH];
    int            clear_left;
    logic [DW-1:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        clear_left = 0;
    endtask

    function automatic void model_read(input logic [AW-1:0] addr, input bit byp,
                                       output logic [DW-1:0] d, output logic b);
        if (int'(addr) == ZR) begin
            d = '0;
            b = 1'b0;
        end else if (clear_left > 0) begin
            d = m_mem[addr];
            b = 1'b1;
        end else if (byp && wr_en && (wr_addr == addr)) begin
            d = wr_data;
            b = 1'b0;
        end else begin
            d = m_mem[addr];
            b = m_pend[addr];
        end
    endfunction

    task automatic model_tick();
        if (clear_left > 0) begin
            m_mem[DEPTH - clear_left]  = '0;
            m_pend[DEPTH - clear_left] = 1'b0;
            clear_left--;
        end else begin
            if (wr_en && int'(wr_addr) != ZR) m_mem[wr_addr] = wr_data;
            if (wr_en) m_pend[wr_addr] = 1'b0;
            if (rsv_en && int'(rsv_addr) != ZR) m_pend[rsv_addr] = 1'b1;
            if (clr_req) clear_left = DEPTH;
        end
    endtask

    task automatic model_check();
        logic [DW-1:0] d;
        logic          b;
        model_read(rd_addr_a, 1'b1, d, b); exp_q.push_back(d); exp_q.push_back(DW'(b));
        model_read(rd_addr_b, 1'b1, d, b); exp_q.push_back(d); exp_q.push_back(DW'(b));
        model_read(rd_addr_a, 1'b0, d, b); exp_q.push_back(d); exp_q.push_back(DW'(b));
        model_read(rd_addr_b, 1'b0, d, b); exp_q.push_back(d); exp_q.push_back(DW'(b));
        exp_q.push_back(DW'(clear_left > 0));
        check("rd_data_a",    rd_data_a,        exp_q.pop_front());
        check("busy_a",       DW'(busy_a),      exp_q.pop_front());
        check("rd_data_b",    rd_data_b,        exp_q.pop_front());
        check("busy_b",       DW'(busy_b),      exp_q.pop_front());
        check("rd_data_a_nb", rd_data_a_nb,     exp_q.pop_front());
        check("busy_a_nb",    DW'(busy_a_nb),   exp_q.pop_front());
        check("rd_data_b_nb", rd_data_b_nb,     exp_q.pop_front());
        check("busy_b_nb",    DW'(busy_b_nb),   exp_q.pop_front());
        d = exp_q.pop_front();
        check("clr_busy",     DW'(clr_busy),    d);
        check("clr_busy_nb",  DW'(clr_busy_nb), d);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
    endtask

    task automatic step(input bit chk);
        @(negedge clk);
        if (chk) model_check();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_inputs();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step(1'b1);
        idle_inputs();
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] rsa;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] ea;
        logic          eba;
        logic [DW-1:0] eb;
        logic          ebb;
        logic [DW-1:0] eb_nb;
        logic          ebb_nb;
    } vec_t;

    vec_t vecs [14];
    int   clr_cycles;
    bit   saw_idle;

    initial begin
        // Directed vectors applied from the reset state, one per cycle.
        vecs[0]  = '{0, 0,  0,      0, 0,  3,  31, 0,      0, 0,      0, 0,      0};
        vecs[1]  = '{1, 3,  'h1234, 0, 0,  3,  5,  'h1234, 0, 0,      0, 0,      0};
        vecs[2]  = '{0, 0,  0,      0, 0,  3,  31, 'h1234, 0, 0,      0, 0,      0};
        vecs[3]  = '{1, 31, 'hFFFF, 0, 0,  31, 31, 0,      0, 0,      0, 0,      0};
        vecs[4]  = '{0, 0,  0,      0, 0,  31, 3,  0,      0, 'h1234, 0, 'h1234, 0};
        vecs[5]  = '{1, 5,  'hABCD, 0, 0,  3,  5,  'h1234, 0, 'hABCD, 0, 0,      0};
        vecs[6]  = '{0, 0,  0,      1, 7,  7,  5,  0,      0, 'hABCD, 0, 'hABCD, 0};
        vecs[7]  = '{0, 0,  0,      0, 0,  7,  7,  0,      1, 0,      1, 0,      1};
        vecs[8]  = '{1, 7,  'h77,   0, 0,  7,  7,  'h77,   0, 'h77,   0, 0,      1};
        vecs[9]  = '{0, 0,  0,      0, 0,  7,  7,  'h77,   0, 'h77,   0, 'h77,   0};
        vecs[10] = '{1, 7,  'h99,   1, 7,  7,  7,  'h99,   0, 'h99,   0, 'h77,   0};
        vecs[11] = '{0, 0,  0,      0, 0,  7,  7,  'h99,   1, 'h99,   1, 'h99,   1};
        vecs[12] = '{0, 0,  0,      1, 31, 31, 5,  0,      0, 'hABCD, 0, 'hABCD, 0};
        vecs[13] = '{0, 0,  0,      0, 0,  31, 7,  0,      0, 'h99,   1, 'h99,   1};

        idle_inputs();
        rd_addr_a = '0;
        rd_addr_b = '0;
        model_reset();

        #2 rst_n = 1'b0;
        #10;
        check("reset_rd_data_a", rd_data_a, '0);
        check("reset_busy_a", DW'(busy_a), '0);
        check("reset_clr_busy", DW'(clr_busy), '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        for (int i = 0; i < 14; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rsv_en = vecs[i].re; rsv_addr = vecs[i].rsa;
            rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
            @(negedge clk);
            check($sformatf("vec%0d_rd_data_a", i), rd_data_a, vecs[i].ea);
            check($sformatf("vec%0d_busy_a", i), DW'(busy_a), DW'(vecs[i].eba));
            check($sformatf("vec%0d_rd_data_b", i), rd_data_b, vecs[i].eb);
            check($sformatf("vec%0d_busy_b", i), DW'(busy_b), DW'(vecs[i].ebb));
            check($sformatf("vec%0d_rd_data_b_nb", i), rd_data_b_nb, vecs[i].eb_nb);
            check($sformatf("vec%0d_busy_b_nb", i), DW'(busy_b_nb), DW'(vecs[i].ebb_nb));
            @(posedge clk);
            model_tick();
            #1;
        end
        idle_inputs();

        // Bulk clear: fill r0..r4, pulse clr_req, hammer writes/reserves during the clear.
        for (int i = 0; i < 5; i++) do_write(AW'(i), DW'(64'h1000 + i));
        rsv_en = 1'b1; rsv_addr = 5'd2;
        step(1'b1);
        idle_inputs();
        clr_req = 1'b1;
        rd_addr_a = 5'd1;
        step(1'b1);
        clr_cycles = 0;
        saw_idle = 1'b0;
        for (int i = 0; i < 100 && !saw_idle; i++) begin
            wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hDEAD;
            rsv_en = 1'b1; rsv_addr = 5'd4; clr_req = 1'b1;
            rd_addr_a = 5'($urandom_range(0, 30));
            rd_addr_b = 5'd4;
            @(negedge clk);
            model_check();
            if (clr_busy) begin
                clr_cycles++;
                @(posedge clk);
                model_tick();
                #1;
            end else begin
                saw_idle = 1'b1;
            end
        end
        idle_inputs();
        check("clr_busy_cycles", DW'(clr_cycles), DW'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(DEPTH - 1 - i);
            @(negedge clk);
            check($sformatf("post_clear_r%0d", i), rd_data_a, '0);
            check($sformatf("post_clear_busy_r%0d", i), DW'(busy_a), '0);
            @(posedge clk);
            model_tick();
            #1;
        end

        // Reset asserted between edges in the middle of a clear.
        do_write(5'd20, 64'hDEAD_BEEF_0000_0020);
        clr_req = 1'b1;
        step(1'b1);
        idle_inputs();
        rd_addr_a = 5'd20;
        rd_addr_b = 5'd20;
        for (int i = 0; i < 4; i++) step(1'b1);
        rst_n = 1'b0;
        #2;
        check("midclr_rst_clr_busy", DW'(clr_busy), '0);
        check("midclr_rst_clr_busy_nb", DW'(clr_busy_nb), '0);
        check("midclr_rst_state", DW'(dbg_state), '0);
        check("midclr_rst_r20", rd_data_a, '0);
        check("midclr_rst_busy_r20", DW'(busy_a), '0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // Randomized traffic against the array model.
        for (int i = 0; i < 400; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = {$urandom(), $urandom()};
            rsv_en = 1'($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 31));
            clr_req = 1'($urandom_range(0, 99) == 0);
            rd_addr_a = ($urandom_range(0, 1) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr_b = 5'($urandom_range(0, 31));
            step(1'b1);
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
